// File: rtl/swt16_pkg.sv
// Shared widths and the queued-write entry type for the
// register-file writeback path.
package swt16_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IDX_WIDTH  = 4;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [WORD_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_cam_lookup.sv
// Age-ordered match of one source index against the live
// entries of the writeback queue; youngest match wins.
import swt16_pkg::*;

module wb_cam_lookup #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t             ent_i [DEPTH],
    input  logic [PW-1:0]         head_i,
    input  logic [PW:0]           count_i,
    input  logic [IDX_WIDTH-1:0]  src_i,
    output logic                  hit_o,
    output logic [WORD_WIDTH-1:0] data_o
);

    logic [PW-1:0] pos;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        pos    = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head_i + PW'(k);
            if (((PW+1)'(k) < count_i) && (src_i != '0) &&
                (ent_i[pos].idx == src_i)) begin
                hit_o  = 1'b1;
                data_o = ent_i[pos].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file's only
// write port, with load-priority intake and two bypass lookups.
import swt16_pkg::*;

module regfile_wb_queue #(
    parameter  int WORD_WIDTH = swt16_pkg::WORD_WIDTH,
    parameter  int IDX_WIDTH  = swt16_pkg::IDX_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [IDX_WIDTH-1:0]  ld_idx,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [IDX_WIDTH-1:0]  alu_idx,
    input  logic [WORD_WIDTH-1:0] alu_data,
    input  logic                  rf_stall,
    output logic                  rf_write,
    output logic [IDX_WIDTH-1:0]  rf_dst_idx,
    output logic [WORD_WIDTH-1:0] rf_dst,
    input  logic [IDX_WIDTH-1:0]  src1_idx,
    input  logic [IDX_WIDTH-1:0]  src2_idx,
    output logic                  byp1_hit,
    output logic                  byp2_hit,
    output logic [WORD_WIDTH-1:0] byp1_data,
    output logic [WORD_WIDTH-1:0] byp2_data,
    output logic [PW:0]           count,
    output logic                  empty
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     enq;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          full, push, pop;
    logic          ld_fire, alu_fire;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

    // Readiness looks only at the current count, never at a same-cycle pop.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;

    assign enq  = ld_valid ? {ld_idx, ld_data} : {alu_idx, alu_data};
    assign push = (ld_fire || alu_fire) && (enq.idx != '0);
    assign pop  = !empty && !rf_stall;

    assign rf_write   = pop;
    assign rf_dst_idx = empty ? '0 : mem_q[head_q].idx;
    assign rf_dst     = empty ? '0 : mem_q[head_q].data;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= enq;
    end

    wb_cam_lookup #(.DEPTH(DEPTH)) u_cam1 (
        .ent_i   (mem_q),
        .head_i  (head_q),
        .count_i (count_q),
        .src_i   (src1_idx),
        .hit_o   (byp1_hit),
        .data_o  (byp1_data)
    );

    wb_cam_lookup #(.DEPTH(DEPTH)) u_cam2 (
        .ent_i   (mem_q),
        .head_i  (head_q),
        .count_i (count_q),
        .src_i   (src2_idx),
        .hit_o   (byp2_hit),
        .data_o  (byp2_data)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboarded random and directed bench for regfile_wb_queue.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0, alu_valid = 1'b0;
    logic        ld_ready, alu_ready;
    logic [3:0]  ld_idx = '0, alu_idx = '0;
    logic [15:0] ld_data = '0, alu_data = '0;
    logic        rf_stall = 1'b0, rf_write;
    logic [3:0]  rf_dst_idx;
    logic [15:0] rf_dst;
    logic [3:0]  src1_idx = '0, src2_idx = '0;
    logic        byp1_hit, byp2_hit;
    logic [15:0] byp1_data, byp2_data;
    logic [2:0]  count;
    logic        empty;

    ent_t sb[$];
    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;

    regfile_wb_queue dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_idx(ld_idx), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_idx(alu_idx), .alu_data(alu_data),
        .rf_stall(rf_stall), .rf_write(rf_write),
        .rf_dst_idx(rf_dst_idx), .rf_dst(rf_dst),
        .src1_idx(src1_idx), .src2_idx(src2_idx),
        .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
        .byp1_data(byp1_data), .byp2_data(byp2_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void byp_model(input logic [3:0] s,
                                      output logic hit,
                                      output logic [15:0] d);
        hit = 1'b0;
        d   = '0;
        if (s != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].idx == s) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    // Scoreboard monitor: every register-file write must match the next accepted entry.
    always @(negedge clk) begin
        if (rst_n && rf_write) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rf_write_unexpected: got idx %0h data %0h expected none",
                         rf_dst_idx, rf_dst);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("wr_idx", rf_dst_idx, e.idx);
                chk("wr_data", rf_dst, e.data);
            end
        end
    end

    task automatic step(input logic lv, input logic [3:0] li, input logic [15:0] ldd,
                        input logic av, input logic [3:0] ai, input logic [15:0] ad,
                        input logic st, input logic [3:0] s1, input logic [3:0] s2,
                        output logic acc_ld, output logic acc_alu);
        int          n;
        logic        h;
        logic [15:0] d;
        ent_t        e;
        @(posedge clk);
        #1;
        ld_valid = lv;  ld_idx = li;  ld_data = ldd;
        alu_valid = av; alu_idx = ai; alu_data = ad;
        rf_stall = st;  src1_idx = s1; src2_idx = s2;
        @(negedge clk);
        n = mq.size();
        chk("ld_ready", ld_ready, n < DEPTH);
        chk("alu_ready", alu_ready, (n < DEPTH) && !lv);
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("rf_write", rf_write, (n > 0) && !st);
        chk("dst_idx", rf_dst_idx, (n > 0) ? mq[0].idx : 0);
        chk("dst_data", rf_dst, (n > 0) ? mq[0].data : 0);
        byp_model(s1, h, d);
        chk("byp1_hit", byp1_hit, h);
        chk("byp1_data", byp1_data, d);
        byp_model(s2, h, d);
        chk("byp2_hit", byp2_hit, h);
        chk("byp2_data", byp2_data, d);
        acc_ld  = lv && (n < DEPTH);
        acc_alu = av && (n < DEPTH) && !lv;
        if ((n > 0) && !st) void'(mq.pop_front());
        if (acc_ld || acc_alu) begin
            e.idx  = acc_ld ? li : ai;
            e.data = acc_ld ? ldd : ad;
            if (e.idx != 0) begin
                mq.push_back(e);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic st, input logic [3:0] s1, input logic [3:0] s2);
        logic a, b;
        step(0, 0, 0, 0, 0, 0, st, s1, s2, a, b);
    endtask

    task automatic alu(input logic [3:0] i, input logic [15:0] d, input logic st,
                       output logic acc);
        logic a;
        step(0, 0, 0, 1, i, d, st, 1, 2, a, acc);
    endtask

    initial begin
        logic a, b;
        logic lv, av;
        logic [3:0]  li, ai;
        logic [15:0] ldd, ad;

        // Reset values while held in reset.
        #12;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_dst_idx", rf_dst_idx, 0);
        chk("rst_dst", rf_dst, 0);
        chk("rst_byp1_hit", byp1_hit, 0);
        chk("rst_byp2_hit", byp2_hit, 0);
        chk("rst_byp1_data", byp1_data, 0);
        ld_valid = 1'b1;
        #1;
        chk("rst_alu_ready_ldv", alu_ready, 0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Load wins over ALU, ALU follows a cycle later.
        step(1, 3, 16'h1111, 1, 5, 16'h2222, 0, 3, 5, a, b);
        chk("arb_ld_first", a, 1);
        step(0, 0, 0, 1, 5, 16'h2222, 0, 3, 5, a, b);
        idle(0, 3, 5);
        idle(0, 3, 5);

        // Fill under stall, full-queue release with held valid.
        alu(1, 16'h000A, 1, a);
        alu(2, 16'h000B, 1, a);
        alu(1, 16'h000C, 1, a);
        alu(4, 16'h000D, 1, a);
        idle(1, 1, 4);
        chk("full_count", count, 4);
        chk("full_byp1", byp1_data, 16'h000C);
        alu(6, 16'h0066, 1, a);
        alu(6, 16'h0066, 0, a);
        chk("full_no_accept_release", a, 0);
        alu(6, 16'h0066, 0, a);
        chk("accept_after_release", a, 1);
        for (int i = 0; i < 6; i++) idle(0, 6, 1);
        chk("drained_empty", empty, 1);

        // Index 0 completes the handshake but is dropped.
        alu(0, 16'hFFFF, 0, a);
        chk("idx0_accept", a, 1);
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Asynchronous reset mid-cycle with three entries queued.
        alu(1, 16'h0101, 1, a);
        alu(2, 16'h0202, 1, a);
        alu(3, 16'h0303, 1, a);
        idle(1, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_rf_write", rf_write, 0);
        chk("arst_byp1_hit", byp1_hit, 0);
        chk("arst_byp2_hit", byp2_hit, 0);
        mq.delete();
        sb.delete();
        rf_stall = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic honouring valid-hold rules.
        lv = 0; av = 0; li = 0; ai = 0; ldd = 0; ad = 0;
        a = 1; b = 1;
        for (int c = 0; c < 400; c++) begin
            if (!lv || a) begin
                lv  = ($urandom_range(0, 9) < 4);
                li  = 4'($urandom_range(0, 7));
                ldd = 16'($urandom);
            end
            if (!av || b) begin
                av = ($urandom_range(0, 9) < 6);
                ai = 4'($urandom_range(0, 7));
                ad = 16'($urandom);
            end
            step(lv, li, ldd, av, ai, ad, ($urandom_range(0, 9) < 4),
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), a, b);
        end

        for (int i = 0; i < 6; i++) idle(0, 0, 0);
        chk("final_empty", empty, 1);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue that sits in front of the register file's single write port and acts as its only writer. Accepts results from the load unit and the ALU over valid/ready, buffers up to DEPTH pending writes in order, and drains one per cycle into the register file whenever the port is not stalled. Provides youngest-match bypass lookups for two source indices so decode sees values that are still queued.

## Interface
- WORD_WIDTH, 16, data word width
- IDX_WIDTH, 4, register index width
- DEPTH, 4, queue entries; power of two, at least 2
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low
- ld_valid / ld_ready  in / out  1 / 1  load-result handshake
- ld_idx, ld_data  in  IDX_WIDTH, WORD_WIDTH  load destination and value
- alu_valid / alu_ready  in / out  1 / 1  ALU-result handshake
- alu_idx, alu_data  in  IDX_WIDTH, WORD_WIDTH  ALU destination and value
- rf_stall  in  1  register-file port unavailable this cycle
- rf_write  out  1  write strobe to register file
- rf_dst_idx, rf_dst  out  IDX_WIDTH, WORD_WIDTH  write index and data
- src1_idx, src2_idx  in  IDX_WIDTH  bypass lookup indices
- byp1_hit, byp2_hit  out  1  a queued entry matches srcN_idx
- byp1_data, byp2_data  out  WORD_WIDTH  value of youngest match
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Arbitration: load has fixed priority. ld_ready = (count < DEPTH); alu_ready = (count < DEPTH) && !ld_valid. At most one enqueue per cycle.
- Handshake completes on a rising edge with valid && ready. Valid must stay high with stable idx/data until accepted.
- Index 0: handshake completes normally, but the entry is discarded and never enqueued.
- Dequeue: rf_write = !empty && !rf_stall. Head entry pops on the same edge the register file samples it.
- rf_dst_idx and rf_dst show the head entry when !empty, otherwise 0.
- Bypass: combinational search of stored entries only, youngest to oldest; the first index match wins. No hit -> hit = 0 and data = 0. Index 0 never hits. A value being enqueued in the current cycle is not visible.
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance.
- Ready is based on the current count only. When full, ready stays low even if a dequeue happens in the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: count 0, empty 1, rf_write 0, rf_dst_idx 0, rf_dst 0, byp*_hit 0, byp*_data 0, ld_ready 1, alu_ready = !ld_valid. Entry storage is not cleared.
- Reset mid-operation discards all pending entries immediately (asynchronous). Accepts in progress are lost.
- Latency: accepted at edge N into an empty queue -> rf_write is high during cycle N..N+1 -> the register file is written at edge N+1, unless stalled.
- Bypass becomes visible the cycle after acceptance and disappears the cycle after the entry drains.
- Throughput: 1 accept per cycle and 1 drain per cycle.

## Structure
- Package swt16_pkg holds:
  - default WORD_WIDTH and IDX_WIDTH
  - the wb_entry_t struct {idx, data}
- Sub-module wb_cam_lookup performs the age-ordered match over the entry array and pointers. It is instantiated twice, once per source.
- The top level holds the FIFO storage, pointers, count, and arbitration.

## Test plan
- Reset, ld_valid=0 -> ld_ready=1, alu_ready=1, empty=1, rf_write=0, all bypass outputs 0.
- ld_valid and alu_valid high together (ld r3=0x1111, alu r5=0x2222), rf_stall=0:
  - load is accepted first and drains as rf_write with idx 3 / 0x1111.
  - the ALU entry follows one cycle later (idx 5 / 0x2222).
- rf_stall=1, accept 4 ALU writes (r1=0xA, r2=0xB, r1=0xC, r4=0xD) -> count=4, alu_ready=0, src1_idx=1 gives hit=1 with 0xC. Release stall -> writes drain in order on 4 consecutive cycles, then empty=1.
- alu_idx=0 with data 0xFFFF -> alu_ready=1, count stays 0, rf_write never asserts.
- Full queue, stall released with alu_valid held -> no accept in the release cycle. Accept on the next edge, count goes 4→3→3.
- Assert reset low asynchronously mid-cycle with 3 entries queued -> count=0, rf_write=0 and byp*_hit=0 immediately, before the next clock edge.
